// File: rtl/alu_pkg.sv
// alu_pkg: opcode and FSM state types plus flag bit positions shared by alu_pipe
package alu_pkg;
  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_MUL  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_NOTA = 3'd5,
    OP_SUB  = 3'd6,
    OP_ILL  = 3'd7
  } op_e;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;
endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add multiplier retiring W/MUL_CYC multiplier bits per cycle
//   CLK, rst_n : clock, async active-low reset
//   start      : load A/B and begin a MUL_CYC-cycle multiply
//   done       : high in the last busy cycle; product is final while done is high
//   product    : 2W-bit product
module alu_mul_seq #(
  parameter int W = 8,
  parameter int MUL_CYC = W
) (
  input  logic           CLK,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  output logic           done,
  output logic [2*W-1:0] product
);
  localparam int K = W / MUL_CYC;
  localparam int CW = $clog2(MUL_CYC + 1);
  logic [CW-1:0] cnt;
  logic [2*W-1:0] a_r, acc, step;
  logic [W-1:0] b_r;
  assign step = a_r * {{(2*W-K){1'b0}}, b_r[K-1:0]};
  // product includes the step being retired this cycle, so it is final while done is high
  assign product = acc + step;
  assign done = cnt == CW'(1);
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      a_r <= '0;
      b_r <= '0;
      acc <= '0;
    end else if (start) begin
      cnt <= CW'(MUL_CYC);
      a_r <= {{W{1'b0}}, A};
      b_r <= B;
      acc <= '0;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
      a_r <= a_r << K;
      b_r <= b_r >> K;
      acc <= product;
    end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: valid/ready ALU with single-cycle logic/add ops and an iterative multiplier
//   CLK, rst_n           : clock, async active-low reset
//   in_valid/in_ready    : request handshake, A/B/OP captured on acceptance
//   A, B (W), OP (3)     : operands and opcode (see alu_pkg::op_e)
//   out_valid/out_ready  : result handshake, out_valid high exactly in DONE
//   result (2W), err     : zero-extended result, illegal-opcode indicator
//   flags (4, Z C N V)   : only when ALU_FLAGS_EN is defined
module alu_pipe import alu_pkg::*; #(
  parameter int W = 8,
  parameter int MUL_CYC = W
) (
  input  logic           CLK,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  input  logic [2:0]     OP,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] result,
  output logic           err
`ifdef ALU_FLAGS_EN
  , output logic [3:0]   flags
`endif
);
  state_e state, nxt;
  op_e op;
  logic accept, mul_start, mul_done, alu_ld, mul_ld;
  logic [2*W-1:0] mul_p, alu_r;
  logic [W:0] sum;
  logic [W-1:0] dif;
  assign op = op_e'(OP);
  assign in_ready = state == IDLE || (state == DONE && out_ready);
  assign out_valid = state == DONE;
  assign accept = in_valid && in_ready;
  assign mul_start = accept && op == OP_MUL;
  assign alu_ld = accept && op != OP_MUL;
  assign mul_ld = state == BUSY && mul_done;
  assign sum = {1'b0, A} + {1'b0, B};
  assign dif = A - B;
  assign alu_r = op == OP_ADD  ? {{(W-1){1'b0}}, sum} :
                 op == OP_SUB  ? {{W{1'b0}}, dif} :
                 op == OP_AND  ? {{W{1'b0}}, A & B} :
                 op == OP_OR   ? {{W{1'b0}}, A | B} :
                 op == OP_XOR  ? {{W{1'b0}}, A ^ B} :
                 op == OP_NOTA ? {{W{1'b0}}, ~A} : '0;
  alu_mul_seq #(.W(W), .MUL_CYC(MUL_CYC)) u_mul (
    .CLK(CLK),
    .rst_n(rst_n),
    .start(mul_start),
    .A(A),
    .B(B),
    .done(mul_done),
    .product(mul_p)
  );
  // a request accepted in DONE is treated exactly like one accepted in IDLE
  always_comb begin
    nxt = state;
    if (state == BUSY) nxt = mul_done ? DONE : BUSY;
    else if (accept) nxt = op == OP_MUL ? BUSY : DONE;
    else if (state == DONE && out_ready) nxt = IDLE;
  end
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      result <= '0;
      err <= 1'b0;
    end else begin
      state <= nxt;
      if (alu_ld) begin
        result <= alu_r;
        err <= op == OP_ILL;
      end else if (mul_ld) begin
        result <= mul_p;
        err <= 1'b0;
      end
    end
`ifdef ALU_FLAGS_EN
  logic [3:0] flg;
  always_comb begin
    flg = '0;
    flg[FLAG_Z] = alu_r == '0;
    flg[FLAG_C] = op == OP_ADD ? sum[W] : op == OP_SUB && A < B;
    flg[FLAG_N] = (op == OP_ADD || op == OP_SUB) && alu_r[W-1];
    flg[FLAG_V] = op == OP_ADD ? A[W-1] == B[W-1] && sum[W-1] != A[W-1] :
                  op == OP_SUB && A[W-1] != B[W-1] && dif[W-1] != A[W-1];
  end
  always_ff @(posedge CLK or negedge rst_n)
    if (!rst_n) flags <= '0;
    else if (alu_ld) flags <= flg;
    else if (mul_ld) flags <= (mul_p == '0) ? 4'(1 << FLAG_Z) : 4'd0;
`endif
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: randomized self-checking bench for alu_pipe against an arithmetic reference model
module tb_alu_pipe;
  localparam int W = 8;
  localparam int MC = 8;
  logic CLK = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, err;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [2:0] OP = '0;
  logic [2*W-1:0] result;
`ifdef ALU_FLAGS_EN
  logic [3:0] flags;
`endif
  int checks = 0;
  int failures = 0;

  alu_pipe #(.W(W), .MUL_CYC(MC)) dut (
    .CLK(CLK),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .A(A),
    .B(B),
    .OP(OP),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result(result),
    .err(err)
`ifdef ALU_FLAGS_EN
    , .flags(flags)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {err, result}
  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    longint m, ua, ub, r;
    m = longint'(1) << W;
    ua = longint'(a);
    ub = longint'(b);
    case (op)
      3'd0: r = ua + ub;
      3'd1: r = ua * ub;
      3'd2: r = ua & ub;
      3'd3: r = ua | ub;
      3'd4: r = ua ^ ub;
      3'd5: r = m - 1 - ua;
      3'd6: r = (ua - ub + m) % m;
      default: r = 0;
    endcase
    return {op == 3'd7, r[2*W-1:0]};
  endfunction

`ifdef ALU_FLAGS_EN
  // {Z, C, N, V}
  function automatic logic [3:0] fmodel(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    logic [2*W:0] e;
    longint m, sa, sb, s;
    logic z, c, n, v;
    e = model(a, b, op);
    m = longint'(1) << W;
    sa = a >= m / 2 ? longint'(a) - m : longint'(a);
    sb = b >= m / 2 ? longint'(b) - m : longint'(b);
    z = e[2*W-1:0] == 0;
    c = 1'b0;
    n = 1'b0;
    v = 1'b0;
    if (op == 3'd0 || op == 3'd6) begin
      s = op == 3'd0 ? sa + sb : sa - sb;
      c = op == 3'd0 ? longint'(a) + longint'(b) >= m : a < b;
      n = e[W-1];
      v = s >= m / 2 || s < -(m / 2);
    end
    return {z, c, n, v};
  endfunction
`endif

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op, input int hold);
    logic [2*W:0] e;
    logic [2*W-1:0] r0;
    int n, lo, unstable;
    e = model(a, b, op);
    @(negedge CLK);
    check("idle_ready", in_ready, 1);
    in_valid = 1'b1;
    A = a;
    B = b;
    OP = op;
    out_ready = 1'b0;
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    lo = 0;
    @(negedge CLK);
    n = 1;
    while (!out_valid && n < 40) begin
      if (!in_ready) lo++;
      A = W'($urandom);
      B = W'($urandom);
      OP = 3'($urandom_range(0, 7));
      in_valid = 1'($urandom_range(0, 1));
      @(negedge CLK);
      n++;
    end
    in_valid = 1'b0;
    check("latency", n, op == 3'd1 ? MC + 1 : 1);
    check("busy_not_ready", lo, op == 3'd1 ? MC : 0);
    check("result", result, e[2*W-1:0]);
    check("err", err, e[2*W]);
`ifdef ALU_FLAGS_EN
    check("flags", flags, fmodel(a, b, op));
`endif
    r0 = result;
    unstable = 0;
    repeat (hold) begin
      @(negedge CLK);
      if (!out_valid || result !== r0 || err !== e[2*W]) unstable++;
    end
    if (hold > 0) check("hold_stable", unstable, 0);
    out_ready = 1'b1;
    @(negedge CLK);
    check("release", out_valid, 0);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [W-1:0] a, b;
    logic [2:0] op;
    logic [2*W:0] e;
    int seen;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_err", err, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge CLK);
    rst_n = 1'b1;
    @(posedge CLK);
    #1;
    check("ready_after_rst", in_ready, 1);

    run_op(8'hFF, 8'h01, 3'd0, 0);
    run_op(8'hFF, 8'hFF, 3'd1, 0);
    run_op(8'h0F, 8'h00, 3'd5, 5);
    run_op(8'h00, 8'h01, 3'd6, 0);
    run_op(8'h00, 8'h5A, 3'd1, 2);
    run_op(8'h7F, 8'h01, 3'd0, 1);
    run_op(8'h80, 8'h01, 3'd6, 0);

    @(negedge CLK);
    out_ready = 1'b1;
    in_valid = 1'b1;
    A = 8'h00;
    B = 8'h00;
    OP = 3'd7;
    @(negedge CLK);
    check("ill_valid", out_valid, 1);
    check("ill_result", result, 0);
    check("ill_err", err, 1);
    check("b2b_ready", in_ready, 1);
    A = 8'h02;
    B = 8'h03;
    OP = 3'd0;
    @(negedge CLK);
    check("b2b_valid", out_valid, 1);
    check("b2b_result", result, 16'h0005);
    check("b2b_err", err, 0);
    for (int i = 0; i < 30; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      do op = 3'($urandom_range(0, 7)); while (op == 3'd1);
      e = model(a, b, op);
      A = a;
      B = b;
      OP = op;
      @(negedge CLK);
      check("stream_valid", out_valid, 1);
      check("stream_result", result, e[2*W-1:0]);
      check("stream_err", err, e[2*W]);
`ifdef ALU_FLAGS_EN
      check("stream_flags", flags, fmodel(a, b, op));
`endif
    end
    in_valid = 1'b0;
    @(negedge CLK);
    check("stream_drain", out_valid, 0);
    out_ready = 1'b0;

    for (int i = 0; i < 40; i++)
      run_op(W'($urandom), W'($urandom), 3'($urandom_range(0, 7)), int'($urandom_range(0, 3)));

    @(negedge CLK);
    in_valid = 1'b1;
    A = 8'h10;
    B = 8'h10;
    OP = 3'd1;
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    repeat (4) @(negedge CLK);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_result", result, 0);
    check("midrst_err", err, 0);
    @(negedge CLK);
    rst_n = 1'b1;
    #1;
    check("midrst_ready", in_ready, 1);
    seen = 0;
    repeat (20) begin
      @(negedge CLK);
      if (out_valid || result == 16'h0100) seen++;
    end
    check("midrst_no_result", seen, 0);
    run_op(8'h10, 8'h10, 3'd1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
